// File: rtl/vmult_seq_ctrl.sv
// Streams operand pairs from a sync-read buffer through the combinational FP16 multiplier
// and writes products back; one element per cycle, 2-cycle read-to-write pipeline.
module vmult_seq_ctrl #(
  parameter int VLEN   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data_a,
  input  logic [15:0]       rd_data_b,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [15:0]       mul_product,
  input  logic              mul_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W:0]   ovf_cnt,
  output logic [ADDR_W-1:0] ovf_first
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(VLEN);
  localparam logic [ADDR_W:0]   ONE_L   = 1;
  localparam logic [ADDR_W-1:0] ONE_A   = 1;

  state_t              r_state, w_next;
  logic [ADDR_W:0]     r_last;
  logic [ADDR_W-1:0]   r_rd_idx, r_rd_idx_q, r_wr_addr, r_ovf_first;
  logic                r_rd_vld, r_mul_vld, r_aborted;
  logic [15:0]         r_mul_a, r_mul_b;
  logic [ADDR_W:0]     r_ovf_cnt;
  logic [ADDR_W:0]     w_len_c;
  logic                w_kill, w_rd_en, w_wr_en, w_accept;
  logic                w_last_rd, w_last_wr;

  assign w_len_c   = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_kill    = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_last_rd = ({1'b0, r_rd_idx} == r_last);
  assign w_last_wr = ({1'b0, r_wr_addr} == r_last);
  // Abort kills strobes combinationally so nothing is written in the abort cycle.
  assign w_wr_en   = r_mul_vld && !w_kill;

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = (w_len_c == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        w_rd_en = !w_kill;
        if (w_kill)         w_next = S_DONE;
        else if (w_last_rd) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_kill)                      w_next = S_DONE;
        else if (w_wr_en && w_last_wr)   w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= '0;
      r_rd_idx    <= '0;
      r_rd_idx_q  <= '0;
      r_wr_addr   <= '0;
      r_rd_vld    <= 1'b0;
      r_mul_vld   <= 1'b0;
      r_aborted   <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_ovf_cnt   <= '0;
      r_ovf_first <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_vld   <= w_rd_en;
      r_rd_idx_q <= r_rd_idx;
      r_mul_vld  <= r_rd_vld && !w_kill;
      if (w_rd_en) r_rd_idx <= r_rd_idx + ONE_A;
      if (r_rd_vld) begin
        r_mul_a   <= rd_data_a;
        r_mul_b   <= rd_data_b;
        r_wr_addr <= r_rd_idx_q;
      end
      if (w_kill) r_aborted <= 1'b1;
      if (w_wr_en && mul_ovf) begin
        if (r_ovf_cnt == '0) r_ovf_first <= r_wr_addr;
        r_ovf_cnt <= r_ovf_cnt + ONE_L;
      end
      if (w_accept) begin
        r_last      <= w_len_c - ONE_L;
        r_rd_idx    <= '0;
        r_aborted   <= 1'b0;
        r_ovf_cnt   <= '0;
        r_ovf_first <= '0;
      end
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign aborted   = (r_state == S_DONE) && r_aborted;
  assign rd_en     = w_rd_en;
  assign rd_addr   = r_rd_idx;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign wr_en     = w_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = w_wr_en ? mul_product : 16'h0000;
  assign ovf_cnt   = r_ovf_cnt;
  assign ovf_first = r_ovf_first;

endmodule

// File: tb/tb_vmult_seq_ctrl.sv
// Bench for vmult_seq_ctrl: operand buffer and multiplier stub live here; per-cycle
// expectations come from the run timeline (reads 1..N, writes 3..N+2, done N+3 or abort+1).
module tb_vmult_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted, rd_en, wr_en, mul_ovf;
  logic [2:0]  rd_addr, wr_addr, ovf_first;
  logic [15:0] rd_data_a = '0, rd_data_b = '0;
  logic [15:0] mul_a, mul_b, mul_product, wr_data;
  logic [3:0]  ovf_cnt;

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [8];
  logic [15:0] seen_wr [8];
  int          n_cmp = 0, n_err = 0;
  int          seen_nwr, seen_done_at;

  vmult_seq_ctrl #(.VLEN(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .mul_ovf(mul_ovf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovf_cnt(ovf_cnt), .ovf_first(ovf_first)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: exact for 1.0 operands, saturates to inf on exponent overflow.
  function automatic logic [16:0] fmul(input logic [15:0] a, input logic [15:0] b);
    int e;
    e = int'(a[14:10]) + int'(b[14:10]);
    if (a == 16'h3C00) return {1'b0, b};
    if (b == 16'h3C00) return {1'b0, a};
    if (e >= 46) return {1'b1, a[15] ^ b[15], 15'h7C00};
    return {1'b0, a ^ {b[7:0], b[15:8]}};
  endfunction

  assign {mul_ovf, mul_product} = fmul(mul_a, mul_b);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) mem_a[i] = 16'h3C00;
    end
  endtask

  // One run accepted at cycle 0; ta = cycle abort is pulsed (-1 for none).
  task automatic run(input int nreq, input int ta, input bit hold);
    int  n, endc, ta_eff, ec, ef, i;
    bit  eff, e_rd, e_wr;
    logic [16:0] p;
    n      = (nreq > 8) ? 8 : nreq;
    eff    = (n > 0) && (ta >= 1) && (ta <= n + 2);
    ta_eff = eff ? ta : 1000;
    endc   = (n == 0) ? 1 : (eff ? ta + 1 : n + 3);
    ec = 0; ef = 0;
    seen_nwr = 0; seen_done_at = -1;
    for (int k = 0; k <= endc + 1; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (hold && k <= endc);
      len   = 4'(nreq);
      abort = (k == ta);
      @(negedge clk);
      e_rd = (k >= 1) && (k <= n) && (k < ta_eff);
      e_wr = (k >= 3) && (k <= n + 2) && (k < ta_eff);
      chk("rd_en", k, 32'(rd_en), 32'(e_rd));
      chk("wr_en", k, 32'(wr_en), 32'(e_wr));
      chk("busy", k, 32'(busy), 32'((n > 0) && (k >= 1) && (k < endc)));
      chk("done", k, 32'(done), 32'(k == endc));
      chk("aborted", k, 32'(aborted), 32'((k == endc) && eff));
      if (e_rd) chk("rd_addr", k, 32'(rd_addr), 32'(k - 1));
      if (k >= 1) begin
        chk("ovf_cnt", k, 32'(ovf_cnt), 32'(ec));
        if (ec != 0) chk("ovf_first", k, 32'(ovf_first), 32'(ef));
      end
      if (e_wr) begin
        i = k - 3;
        p = fmul(mem_a[i], mem_b[i]);
        chk("wr_addr", k, 32'(wr_addr), 32'(i));
        chk("wr_data", k, 32'(wr_data), 32'(p[15:0]));
        chk("mul_a", k, 32'(mul_a), 32'(mem_a[i]));
        chk("mul_b", k, 32'(mul_b), 32'(mem_b[i]));
        if (p[16]) begin
          if (ec == 0) ef = i;
          ec++;
        end
      end
      if (wr_en) begin
        seen_wr[wr_addr] = wr_data;
        seen_nwr++;
      end
      if (done && seen_done_at < 0) seen_done_at = k;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'h3C00; mem_b[i] = 16'h3C00; seen_wr[i] = '0;
    end
    #2;
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(done), 0);
    chk("rst_rd_en", 0, 32'(rd_en), 0);
    chk("rst_mul_a", 0, 32'(mul_a), 0);
    chk("rst_ovf_cnt", 0, 32'(ovf_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // len=4, all 1.0
    run(4, -1, 1'b0);
    chk("t1_nwr", 0, 32'(seen_nwr), 4);
    chk("t1_done_at", 0, 32'(seen_done_at), 7);
    chk("t1_wr3", 0, 32'(seen_wr[3]), 32'h3C00);
    chk("t1_ovf_cnt", 0, 32'(ovf_cnt), 0);

    // len=2 with overflowing element 1
    mem_a[1] = 16'h7AAA; mem_b[1] = 16'h7ADE;
    run(2, -1, 1'b0);
    chk("t2_wr1", 0, 32'(seen_wr[1]), 32'h7C00);
    chk("t2_ovf_cnt", 0, 32'(ovf_cnt), 1);
    chk("t2_ovf_first", 0, 32'(ovf_first), 1);

    // len=0
    run(0, -1, 1'b0);
    chk("t3_nwr", 0, 32'(seen_nwr), 0);
    chk("t3_done_at", 0, 32'(seen_done_at), 1);

    // len=8 aborted at cycle 5
    run(8, 5, 1'b0);
    chk("t4_nwr", 0, 32'(seen_nwr), 2);
    chk("t4_done_at", 0, 32'(seen_done_at), 6);

    // start held high through a len=3 run, then a fresh run clears ovf state
    mem_a[0] = 16'h7AAA; mem_b[0] = 16'h7ADE;
    run(3, -1, 1'b1);
    chk("t5_nwr", 0, 32'(seen_nwr), 3);
    chk("t5_done_at", 0, 32'(seen_done_at), 6);
    mem_a[0] = 16'h3C00; mem_a[1] = 16'h3C00;
    run(3, -1, 1'b0);
    chk("t5_ovf_cleared", 0, 32'(ovf_cnt), 0);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      int nreq, ta;
      fill_random();
      nreq = $urandom_range(0, 15);
      ta   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 11) : -1;
      run(nreq, ta, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // asynchronous reset in the middle of a len=8 run
    fill_random();
    mem_a[0] = 16'h1234;
    @(posedge clk); #1; start = 1'b1; len = 4'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 4, 32'(busy), 0);
    chk("arst_rd_en", 4, 32'(rd_en), 0);
    chk("arst_wr_en", 4, 32'(wr_en), 0);
    chk("arst_mul_a", 4, 32'(mul_a), 0);
    chk("arst_mul_b", 4, 32'(mul_b), 0);
    chk("arst_wr_data", 4, 32'(wr_data), 0);
    chk("arst_ovf_cnt", 4, 32'(ovf_cnt), 0);
    chk("arst_done", 4, 32'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_done", k, 32'(done), 0);
      chk("post_rst_busy", k, 32'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
